cat_code_gen: RTL and testbench

- Inverse of the categorization circuit.
- Given a requested category, sequentially emits every 6-bit code {e1,e0,p3..p0} that the categorization circuit maps to that category, one code per handshake.
- Used as a stimulus/encoder source feeding the classifier path, and for exhaustive self-check.

---
 rtl/cat_code_gen_pkg.sv | 34 +++
 rtl/cat_code_gen_if.sv | 34 +++
 rtl/cat_code_gen_classify.sv | 14 +
 rtl/cat_code_gen.sv | 90 +++++++++
 tb/tb_cat_code_gen.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cat_code_gen_pkg.sv
// cat_pkg: shared types, per-category first/last index tables and the
// category equations for the cat_code_gen code generator.
package cat_pkg;

  typedef enum logic [1:0] {
    CAT_C1  = 2'd0,
    CAT_C2  = 2'd1,
    CAT_C3  = 2'd2,
    CAT_ERR = 2'd3
  } cat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } gen_state_e;

  // Ascending-scan first/last index per category, indexed by cat_e value.
  localparam logic [3:0][5:0] CAT_FIRST_ASC = {6'd8,  6'd45, 6'd16, 6'd0};
  localparam logic [3:0][5:0] CAT_LAST_ASC  = {6'd60, 6'd63, 6'd28, 6'd7};

  // Category of code idx = {e[1:0], p[3:0]}.
  function automatic cat_e classify(input logic [5:0] idx);
    logic [1:0] e;
    logic [3:0] p;
    e = idx[5:4];
    p = idx[3:0];
    if (e == 2'b00 && p < 4'd8)        return CAT_C1;
    else if (e == 2'b01 && p < 4'd13)  return CAT_C2;
    else if (e[1] && p >= 4'd13)       return CAT_C3;
    else                               return CAT_ERR;
  endfunction

endpackage

// File: rtl/cat_code_gen_if.sv
// Request/code-stream bundle of cat_code_gen. Optional out_count exists
// only when CAT_GEN_COUNT_EN is defined.
interface cat_code_gen_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cat;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_p;
  logic [1:0] out_e;
  logic       out_last;
  logic       done;
`ifdef CAT_GEN_COUNT_EN
  logic [5:0] out_count;

  modport slave (
    input  req_valid, req_cat, out_ready,
    output req_ready, out_valid, out_p, out_e, out_last, done, out_count
  );
  modport master (
    output req_valid, req_cat, out_ready,
    input  req_ready, out_valid, out_p, out_e, out_last, done, out_count
  );
`else
  modport slave (
    input  req_valid, req_cat, out_ready,
    output req_ready, out_valid, out_p, out_e, out_last, done
  );
  modport master (
    output req_valid, req_cat, out_ready,
    input  req_ready, out_valid, out_p, out_e, out_last, done
  );
`endif
endinterface

// File: rtl/cat_code_gen_classify.sv
// cat_classify: combinational code-to-category map.
module cat_classify
  import cat_pkg::*;
(
  input  logic [5:0] idx_i,
  output cat_e       cat_o
);

  // Pure decode of the code fields into a category.
  always_comb begin
    cat_o = classify(idx_i);
  end

endmodule

// File: rtl/cat_code_gen.sv
// cat_code_gen: emits, one per handshake, every 6-bit code {e,p} that
// classifies into the requested category. REVERSE selects scan direction.
// Optional macro CAT_GEN_COUNT_EN adds out_count (handshakes per scan).
module cat_code_gen
  import cat_pkg::*;
#(
  parameter bit REVERSE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  cat_code_gen_if.slave bus
);

  localparam logic [5:0] START_IDX = REVERSE ? 6'd63 : 6'd0;

  gen_state_e state_q;
  logic [5:0] idx_q;
  cat_e       cat_q;
  cat_e       idx_cat;
  logic       match;
  logic       at_last;
  logic [5:0] last_idx;
  logic [5:0] idx_step;
`ifdef CAT_GEN_COUNT_EN
  logic [5:0] count_q;
`endif

  cat_classify u_classify (
    .idx_i (idx_q),
    .cat_o (idx_cat)
  );

  // Scan-order neighbours of the current index.
  always_comb begin
    last_idx = REVERSE ? CAT_FIRST_ASC[cat_q] : CAT_LAST_ASC[cat_q];
    idx_step = REVERSE ? (idx_q - 6'd1) : (idx_q + 6'd1);
    match    = (state_q == ST_SCAN) && (idx_cat == cat_q);
    at_last  = (idx_q == last_idx);
  end

  // Request capture, scan stepping and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cat_q   <= CAT_C1;
`ifdef CAT_GEN_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cat_q   <= cat_e'(bus.req_cat);
            idx_q   <= START_IDX;
            state_q <= ST_SCAN;
`ifdef CAT_GEN_COUNT_EN
            count_q <= '0;
`endif
          end
        end
        ST_SCAN: begin
          if (!match) begin
            idx_q <= idx_step;
          end else if (bus.out_ready) begin
`ifdef CAT_GEN_COUNT_EN
            count_q <= count_q + 6'd1;
`endif
            // The final code ends the scan, so idx never wraps.
            if (at_last) state_q <= ST_DONE;
            else         idx_q   <= idx_step;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.out_valid = match;
  assign bus.out_last  = match && at_last;
  assign bus.out_p     = idx_q[3:0];
  assign bus.out_e     = idx_q[5:4];
  assign bus.done      = (state_q == ST_DONE);
`ifdef CAT_GEN_COUNT_EN
  assign bus.out_count = count_q;
`endif

endmodule

// File: tb/tb_cat_code_gen.sv
// Self-checking bench for cat_code_gen: one ascending and one descending
// instance, driven by randomized requests/backpressure against a
// category model built from the classification rules.
module tb_cat_code_gen;
  import cat_pkg::*;

  logic clk;
  logic rst_n;
  logic sel;
  logic tb_req_valid;
  logic [1:0] tb_req_cat;
  logic out_ready;
  logic [5:0] cls_idx;
  cat_e ref_cls;

  int unsigned n_vec;
  int unsigned n_err;

  cat_code_gen_if ifa ();
  cat_code_gen_if ifb ();

  cat_code_gen #(.REVERSE(1'b0)) u_dut_asc (.clk(clk), .rst_n(rst_n), .bus(ifa));
  cat_code_gen #(.REVERSE(1'b1)) u_dut_desc (.clk(clk), .rst_n(rst_n), .bus(ifb));

  cat_classify u_ref (.idx_i(cls_idx), .cat_o(ref_cls));

  assign ifa.req_valid = tb_req_valid && !sel;
  assign ifb.req_valid = tb_req_valid && sel;
  assign ifa.req_cat   = tb_req_cat;
  assign ifb.req_cat   = tb_req_cat;
  assign ifa.out_ready = out_ready;
  assign ifb.out_ready = out_ready;

  logic       o_req_ready, o_valid, o_last, o_done;
  logic [3:0] o_p;
  logic [1:0] o_e;
  assign o_req_ready = sel ? ifb.req_ready : ifa.req_ready;
  assign o_valid     = sel ? ifb.out_valid : ifa.out_valid;
  assign o_last      = sel ? ifb.out_last  : ifa.out_last;
  assign o_done      = sel ? ifb.done      : ifa.done;
  assign o_p         = sel ? ifb.out_p     : ifa.out_p;
  assign o_e         = sel ? ifb.out_e     : ifa.out_e;
`ifdef CAT_GEN_COUNT_EN
  logic [5:0] o_count;
  assign o_count = sel ? ifb.out_count : ifa.out_count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Category of a code straight from the classification rules.
  function automatic int ref_cat(input int id);
    int e, p;
    e = id / 16;
    p = id % 16;
    if (e == 0 && p < 8)   return 0;
    if (e == 1 && p < 13)  return 1;
    if (e >= 2 && p >= 13) return 2;
    return 3;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_ready"}, o_req_ready, 1);
    check({tag, "_code"}, {o_e, o_p}, 0);
`ifdef CAT_GEN_COUNT_EN
    check({tag, "_count"}, o_count, 0);
`endif
  endtask

  // One request; abort_after >= 0 pulses reset after that many handshakes.
  task automatic run_scan(input bit rev, input int cat, input bit rnd_ready, input int abort_after);
    int q[$];
    int pos, hs, idx_exp;
    bit v_exp, fin, aborted;
    sel = rev;
    for (int i = 0; i < 64; i++) begin
      int id;
      id = rev ? 63 - i : i;
      if (ref_cat(id) == cat) q.push_back(id);
    end
    @(negedge clk);
    check("req_ready_idle", o_req_ready, 1);
    tb_req_valid = 1'b1;
    tb_req_cat   = 2'(cat);
    @(posedge clk);
    @(negedge clk);
    // Descending runs keep req_valid high mid-scan; req_cat is scrambled
    // to confirm it was latched.
    tb_req_valid = rev;
    tb_req_cat   = 2'($urandom_range(0, 3));
    pos = 0; hs = 0; fin = 0; aborted = 0;
    for (int cyc = 0; cyc < 200 && !fin && !aborted; cyc++) begin
      idx_exp   = rev ? 63 - pos : pos;
      v_exp     = (ref_cat(idx_exp) == cat);
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check("req_ready_busy", o_req_ready, 0);
      check("done_busy", o_done, 0);
      check("out_valid", o_valid, v_exp);
      if (v_exp) begin
        check("code", {o_e, o_p}, idx_exp);
        check("out_last", o_last, idx_exp == q[q.size()-1]);
        if (cat == 3) begin
          cls_idx = {o_e, o_p};
          #1;
          check("code_is_err", int'(ref_cls), 3);
        end
        if (out_ready) begin
          hs++;
          if (hs == abort_after) begin
            #1;
            tb_req_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_rst");
            @(negedge clk);
            check_reset_outputs("rst_hold");
            rst_n = 1'b1;
            aborted = 1;
          end else if (hs == q.size()) begin
            fin = 1;
            tb_req_valid = 1'b0;
          end else begin
            pos++;
          end
        end
      end else begin
        pos++;
      end
      if (!aborted) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (aborted) return;
    if (!fin) begin
      check("scan_timeout", 0, 1);
      return;
    end
    check("done_pulse", o_done, 1);
    check("valid_in_done", o_valid, 0);
    check("ready_in_done", o_req_ready, 0);
`ifdef CAT_GEN_COUNT_EN
    check("count_at_done", o_count, q.size());
`endif
    @(posedge clk);
    @(negedge clk);
    check("done_once", o_done, 0);
    check("ready_after", o_req_ready, 1);
    check("held_code", {o_e, o_p}, q[q.size()-1]);
`ifdef CAT_GEN_COUNT_EN
    check("count_hold", o_count, q.size());
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sel = 1'b0;
    tb_req_valid = 1'b0;
    tb_req_cat = '0;
    out_ready = 1'b0;
    cls_idx = '0;
    #12;
    sel = 1'b0; #1; check_reset_outputs("reset_asc");
    sel = 1'b1; #1; check_reset_outputs("reset_desc");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      cls_idx = 6'(i);
      #1;
      check("classify_sweep", int'(ref_cls), ref_cat(i));
    end

    run_scan(1'b0, 0, 1'b0, -1);
    run_scan(1'b0, 2, 1'b0, -1);
    run_scan(1'b0, 1, 1'b1, -1);
    run_scan(1'b0, 3, 1'b0, -1);
    run_scan(1'b0, 3, 1'b0, 5);
    run_scan(1'b0, 0, 1'b0, -1);
    run_scan(1'b1, 0, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      run_scan(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
